// File: rtl/xadc_multichannel_packetizer_pkg.sv
// Shared types and helpers for the XADC multichannel packetizer.
// State encoding, CRC polynomial, header nibbles, channel search.
package xadc_packetizer_package;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SEND_HEADER = 3'd1,
    ST_SEND_UPPER  = 3'd2,
    ST_SEND_LOWER  = 3'd3,
    ST_SEND_CRC    = 3'd4
  } xadc_mc_packetizer_state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  localparam logic [3:0] PACKET_TYPE_LOW_SPEED = 4'h1;

  // Lowest set bit of mask at or above start (0 if none).
  function automatic logic [2:0] find_set_from(
    input logic [7:0] mask,
    input logic [3:0] start
  );
    logic [2:0] r;
    logic       found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && i >= int'(start) && mask[i]) begin
        r     = 3'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // True when no mask bit is set above idx.
  function automatic logic is_top_set(
    input logic [7:0] mask,
    input logic [2:0] idx
  );
    return (mask >> (4'(idx) + 4'd1)) == 8'd0;
  endfunction

endpackage

// File: rtl/xadc_multichannel_packetizer_crc8_update.sv
// Byte-wise CRC-8 update, poly 0x07, MSB first, no reflection.
// Used only when XADC_PACKETIZER_CRC8_EN is defined.
module xadc_crc8_update
  import xadc_packetizer_package::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  // Eight shift/xor steps over the incoming byte.
  always_comb begin
    c = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = (c << 1) ^ CRC8_POLY;
      else      c = c << 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/xadc_multichannel_packetizer.sv
// Gathers one sample per enabled channel into an 8-bit packet.
// Optional trailing CRC byte: define XADC_PACKETIZER_CRC8_EN.
module xadc_multichannel_packetizer
  import xadc_packetizer_package::*;
#(
  parameter int          NUM_CHANNELS = 2,
  parameter int          INPUT_WIDTH  = 16,
  parameter int          SAMPLE_LSB   = 4,
  parameter int          SAMPLE_WIDTH = 12,
  parameter logic [3:0]  PACKET_TYPE  = PACKET_TYPE_LOW_SPEED
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CHANNELS*INPUT_WIDTH-1:0] s_tdata,
  input  logic [NUM_CHANNELS-1:0]             s_tvalid,
  output logic [NUM_CHANNELS-1:0]             s_tready,
  input  logic [NUM_CHANNELS-1:0]             channel_en,
  output logic [7:0]                          m_tdata,
  output logic                                m_tvalid,
  input  logic                                m_tready,
  output logic                                m_tlast,
  output logic                                busy
);

  localparam logic [2:0] IDLE        = ST_IDLE;
  localparam logic [2:0] SEND_HEADER = ST_SEND_HEADER;
  localparam logic [2:0] SEND_UPPER  = ST_SEND_UPPER;
  localparam logic [2:0] SEND_LOWER  = ST_SEND_LOWER;
`ifdef XADC_PACKETIZER_CRC8_EN
  localparam logic [2:0] SEND_CRC    = ST_SEND_CRC;
`endif

  logic [2:0]   state;
  logic [3:0]   seq;
  logic [7:0]   mask_q;
  logic [2:0]   idx;
  logic [127:0] samp_q;
  logic [127:0] samp_d;
  logic [7:0]   en8;
  logic         all_ready;
  logic         hs;
  logic         last_ch;
  logic [2:0]   first_idx;
  logic [2:0]   next_idx;
  logic [15:0]  cur_s;
  logic [15:0]  nxt_s;

  assign en8       = 8'(channel_en);
  assign all_ready = (channel_en != '0) &&
                     ((s_tvalid & channel_en) == channel_en);
  assign hs        = m_tvalid && m_tready;
  assign first_idx = find_set_from(en8, 4'd0);
  assign next_idx  = find_set_from(mask_q, 4'(idx) + 4'd1);
  assign last_ch   = is_top_set(mask_q, idx);
  assign cur_s     = samp_q[{idx, 4'b0000} +: 16];
  assign nxt_s     = samp_q[{next_idx, 4'b0000} +: 16];
  assign busy      = state != IDLE;

  assign s_tready = (!rst && state == IDLE && all_ready)
                  ? channel_en : '0;

  // Extract and zero-extend each channel's sample bits.
  always_comb begin
    samp_d = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      samp_d[i*16 +: 16] =
        16'(s_tdata[i*INPUT_WIDTH+SAMPLE_LSB +: SAMPLE_WIDTH]);
    end
  end

`ifdef XADC_PACKETIZER_CRC8_EN
  logic [7:0] crc_q;
  logic [7:0] crc_next;

  xadc_crc8_update u_crc (
    .crc_in  (crc_q),
    .data_in (m_tdata),
    .crc_out (crc_next)
  );

  // Running CRC over every byte accepted downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                crc_q <= '0;
    else if (state == IDLE) crc_q <= '0;
    else if (hs)            crc_q <= crc_next;
  end
`endif

  // Capture samples once per packet, all channels together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      samp_q <= '0;
    else if (state == IDLE && all_ready)
      samp_q <= samp_d;
  end

  // Packet sequencer: header, then upper/lower per channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
      seq      <= '0;
      mask_q   <= '0;
      idx      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (all_ready) begin
            mask_q   <= en8;
            idx      <= first_idx;
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b0;
            m_tdata  <= {PACKET_TYPE, seq};
            state    <= SEND_HEADER;
          end
        end
        SEND_HEADER: begin
          if (hs) begin
            m_tdata <= cur_s[15:8];
            state   <= SEND_UPPER;
          end
        end
        SEND_UPPER: begin
          if (hs) begin
            m_tdata <= cur_s[7:0];
`ifndef XADC_PACKETIZER_CRC8_EN
            m_tlast <= last_ch;
`endif
            state   <= SEND_LOWER;
          end
        end
        SEND_LOWER: begin
          if (hs) begin
            if (!last_ch) begin
              idx     <= next_idx;
              m_tdata <= nxt_s[15:8];
              m_tlast <= 1'b0;
              state   <= SEND_UPPER;
            end else begin
`ifdef XADC_PACKETIZER_CRC8_EN
              m_tdata <= crc_next;
              m_tlast <= 1'b1;
              state   <= SEND_CRC;
`else
              m_tvalid <= 1'b0;
              m_tlast  <= 1'b0;
              seq      <= seq + 4'd1;
              state    <= IDLE;
`endif
            end
          end
        end
`ifdef XADC_PACKETIZER_CRC8_EN
        SEND_CRC: begin
          if (hs) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            seq      <= seq + 4'd1;
            state    <= IDLE;
          end
        end
`endif
        default: begin
          m_tvalid <= 1'b0;
          m_tlast  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_multichannel_packetizer.sv
// Bench for xadc_multichannel_packetizer (2 channels).
// Packet-level queue model plus directed literal packets.
module tb_xadc_multichannel_packetizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_tdata = '0;
  logic [1:0]  s_tvalid = '0;
  logic [1:0]  s_tready;
  logic [1:0]  channel_en = '0;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic        busy;

  int errors = 0;
  int checks = 0;

`ifdef XADC_PACKETIZER_CRC8_EN
  localparam int XTRA = 1;
`else
  localparam int XTRA = 0;
`endif

  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  logic [3:0] mseq = '0;
  int         cnt_both = 0;
  bit         seen0 = 1'b0;
  bit         seen_any = 1'b0;

  xadc_multichannel_packetizer dut (
    .clk        (clk),
    .rst        (rst),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .channel_en (channel_en),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] c,
                                     input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int b = 7; b >= 0; b--) begin
      if (r[7] ^ d[b]) r = {r[6:0], 1'b0} ^ 8'h07;
      else             r = {r[6:0], 1'b0};
    end
    return r;
  endfunction

  // Model: the packet is a byte queue; DUT must present its head.
  always @(negedge clk) begin
    logic       ev;
    logic       all;
    logic [1:0] er;
    logic [15:0] v;
    logic [7:0] c;
    if (rst) begin
      exp_q.delete();
      mseq = '0;
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tlast", m_tlast, 0);
      chk("rst_tready", s_tready, 0);
    end else begin
      ev  = exp_q.size() != 0;
      all = (channel_en != 0) &&
            ((s_tvalid & channel_en) == channel_en);
      er  = (!ev && all) ? channel_en : 2'b00;
      chk("s_tready", s_tready, er);
      chk("m_tvalid", m_tvalid, ev);
      chk("busy", busy, ev);
      if (ev) begin
        chk("m_tdata", m_tdata, exp_q[0]);
        chk("m_tlast", m_tlast, exp_q.size() == 1);
      end
      if (s_tready == 2'b11) cnt_both++;
      if (s_tready[0]) seen0 = 1'b1;
      if (s_tready != 0) seen_any = 1'b1;
      if (ev && m_tready) begin
        got.push_back(m_tdata);
        void'(exp_q.pop_front());
      end
      if (!ev && all) begin
        exp_q.push_back({4'h1, mseq});
        for (int ch = 0; ch < 2; ch++) begin
          if (channel_en[ch]) begin
            v = {4'h0, s_tdata[ch*16+4 +: 12]};
            exp_q.push_back(v[15:8]);
            exp_q.push_back(v[7:0]);
          end
        end
`ifdef XADC_PACKETIZER_CRC8_EN
        c = 8'h00;
        foreach (exp_q[k]) c = crc8(c, exp_q[k]);
        exp_q.push_back(c);
`else
        c = 8'h00;
`endif
        mseq = mseq + 4'd1;
      end
    end
  end

  task automatic wait_done(input int len, input bit tog);
    for (int c = 0; c < 100; c++) begin
      if (got.size() >= len) break;
      if (tog) m_tready = ~m_tready;
      @(posedge clk); #1;
    end
    chk("pkt_timeout", got.size() >= len, 1);
    m_tready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic pkt(input logic [1:0] en,
                     input logic [31:0] td,
                     input bit tog);
    got.delete();
    cnt_both = 0;
    seen0 = 1'b0;
    channel_en = en;
    s_tdata    = td;
    s_tvalid   = en;
    m_tready   = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 2'b00;
    wait_done(1 + 2 * $countones(en) + XTRA, tog);
  endtask

  function automatic logic [7:0] gb(input int i);
    return (i < got.size()) ? got[i] : 8'hxx;
  endfunction

  logic [7:0] lit[5];

  initial begin
    lit[0] = 8'h10; lit[1] = 8'h0A; lit[2] = 8'hBC;
    lit[3] = 8'h0D; lit[4] = 8'hEF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_tdata", m_tdata, 8'h00);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1;

    // Basic two-channel packet, full throughput.
    pkt(2'b11, 32'hDEF0_ABC0, 1'b0);
    chk("t1_len", got.size(), 5 + XTRA);
    for (int i = 0; i < 5; i++)
      chk("t1_byte", gb(i), lit[i]);
    chk("t1_tready_pulse", cnt_both, 1);

    // Same data, downstream stalling every other cycle.
    pkt(2'b11, 32'hDEF0_ABC0, 1'b1);
    chk("t2_len", got.size(), 5 + XTRA);
    chk("t2_hdr", gb(0), 8'h11);
    for (int i = 1; i < 5; i++)
      chk("t2_byte", gb(i), lit[i]);

    // Channel 1 only.
    pkt(2'b10, 32'h1230_FFF0, 1'b0);
    chk("t3_len", got.size(), 3 + XTRA);
    chk("t3_b0", gb(0), 8'h12);
    chk("t3_b1", gb(1), 8'h01);
    chk("t3_b2", gb(2), 8'h23);
    chk("t3_tready0", seen0, 0);

    // Partial valid must not start a packet.
    got.delete();
    seen_any = 1'b0;
    channel_en = 2'b11;
    s_tdata    = 32'h5550_4440;
    s_tvalid   = 2'b01;
    repeat (5) @(posedge clk);
    #1;
    chk("t4_no_tready", seen_any, 0);
    chk("t4_no_valid", m_tvalid, 0);
    s_tvalid = 2'b11;
    @(posedge clk); #1;
    s_tvalid = 2'b00;
    chk("t4_hdr_valid", m_tvalid, 1);
    chk("t4_hdr", m_tdata, 8'h13);
    wait_done(5 + XTRA, 1'b0);

    // Reset while in the upper-byte state.
    channel_en = 2'b11;
    s_tdata    = 32'h1110_2220;
    s_tvalid   = 2'b11;
    m_tready   = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 2'b00;
    @(posedge clk); #1;
    chk("t5_upper", m_tdata, 8'h02);
    m_tready = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_tvalid", m_tvalid, 0);
    chk("t5_tlast", m_tlast, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_tready = 1'b1;
    @(posedge clk); #1;

    // 17 packets: sequence wraps 15 -> 0.
    for (int k = 0; k < 17; k++) begin
      pkt(2'b11, $urandom, 1'b0);
      chk("seq_hdr", gb(0), 8'(16 + (k % 16)));
    end

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      channel_en = ($urandom_range(0, 3) != 0)
                 ? 2'b11 : 2'($urandom);
      s_tvalid   = ($urandom_range(0, 2) != 0)
                 ? 2'b11 : 2'($urandom);
      s_tdata    = $urandom;
      m_tready   = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
    end
    s_tvalid = 2'b00;
    m_tready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("drain_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
